aes_state_sel_reg: RTL and testbench
====================================

// Module: aes_state_sel_reg
// PURPOSE
//   Registered, handshaked NUM_IN-way selector for the AES state/key datapath.
//   Replaces the combinational 3:1 state mux at round boundaries: sources are
//   initial AddRoundKey, round output, final round, key schedule taps, etc.
//   Supports explicit index selection or round-robin arbitration.
//   Provides one registered output stage with valid/ready backpressure.
// PARAMETERS
//   N       128  data width per input, bits
//   NUM_IN  3    number of input channels, >=2
//   SEL_W   $clog2(NUM_IN)  width of sel/out_src; derived, do not override
// PORTS
//   clk       in   1            rising-edge clock
//   rst_n     in   1            asynchronous reset, active low
//   mode      in   1            0 = explicit sel, 1 = round-robin
//   sel       in   SEL_W        channel index, used when mode=0
//   in_data   in   NUM_IN*N     packed inputs; channel i = [i*N +: N]
//   in_valid  in   NUM_IN       per-channel valid
//   in_ready  out  NUM_IN       per-channel ready, combinational
//   out_data  out  N            registered selected data
//   out_src   out  SEL_W        channel index of out_data
//   out_valid out  1            out_data holds an untaken word
//   out_ready in   1            downstream accepts
//   sel_err   out  1            registered 1-cycle pulse: sel >= NUM_IN while mode=0
// BEHAVIOUR
//   Reset, asynchronous: out_data=0, out_src=0, out_valid=0, sel_err=0,
//     rr_ptr=0. Output register cleared mid-transfer; pending word is lost.
//   load = ~out_valid | out_ready. Register may take a new word every cycle.
//   Grant, combinational, at most one bit set:
//     mode=0: grant[sel] = load & in_valid[sel] when sel < NUM_IN; else none.
//     mode=1: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ...
//       wrapping modulo NUM_IN; grant only when load=1.
//   in_ready[i] = grant[i]. A transfer on channel i = in_valid[i] & in_ready[i].
//   On transfer of channel g: out_data<=in_data[g], out_src<=g, out_valid<=1.
//     Latency: 1 clock from the input transfer to out_valid.
//   No transfer and out_ready=1: out_valid<=0; out_data/out_src hold.
//   No transfer and out_ready=0: all outputs hold.
//   rr_ptr: on a transfer with mode=1, rr_ptr <= (g==NUM_IN-1) ? 0 : g+1.
//     Holds otherwise, including in mode=0. Wrap is to 0; there are no illegal
//     pointer values.
//   sel_err <= (mode==0) & (sel >= NUM_IN) & (|in_valid). Otherwise 0.
//     Never sticky. No x propagation: out-of-range sel grants nothing.
//   Simultaneous: downstream pop and new transfer in the same cycle give
//     out_valid=1, with the new data in the register.
//   mode/sel may change every cycle and are sampled only in the grant cycle.
//   Holding out_data/out_src stable while out_valid=1 & out_ready=0 is mandatory.
// TESTING
//   1 Reset mid-stream: with out_valid=1, assert rst_n=0 asynchronously
//     -> out_valid=0, out_data=0, sel_err=0 before the next clk edge. After
//     release, the first rr grant goes to ch0.
//   2 Explicit mode, NUM_IN=3, sel=1, in_valid=3'b111, ch1=128'hA5.., out_ready=1
//     -> in_ready=3'b010, and next cycle out_data=ch1, out_src=1, out_valid=1.
//   3 Backpressure: out_ready=0 for 4 cycles with in_valid=all 1s
//     -> in_ready=0 after the first load; out_data stable. Raise out_ready
//     -> one new word per cycle, with no bubble.
//   4 Round-robin, in_valid=3'b111 constant, out_ready=1
//     -> out_src sequence 0,1,2,0,1; in_valid=3'b101 -> 0,2,0,2 (wrap skips 1).
//   5 Out-of-range sel: NUM_IN=3, mode=0, sel=3, in_valid=3'b001
//     -> in_ready=0, sel_err=1 for exactly one cycle per such cycle, out_valid
//     does not rise.
//   6 Mode switch mid-stream: rr grants ch0, then mode=0 with sel=2
//     -> ch2 is granted, rr_ptr stays at 1; back to mode=1 -> ch1 is granted next.

Source files
------------

// File: rtl/aes_state_sel_reg.sv
// aes_state_sel_reg: registered, handshaked NUM_IN-way selector for the AES state/key datapath
//   clk       rising-edge clock
//   rst_n     asynchronous reset, active low
//   mode      0 = explicit sel, 1 = round-robin
//   sel       channel index used in explicit mode
//   in_data   packed inputs, channel i = [i*N +: N]
//   in_valid  per-channel valid
//   in_ready  per-channel ready (combinational grant)
//   out_data  registered selected word
//   out_src   channel index of out_data
//   out_valid out_data holds an untaken word
//   out_ready downstream accepts
//   sel_err   one-cycle pulse: out-of-range sel in explicit mode with any input valid
module aes_state_sel_reg #(
    parameter  int N      = 128,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [NUM_IN*N-1:0] in_data,
    input  logic [NUM_IN-1:0]   in_valid,
    output logic [NUM_IN-1:0]   in_ready,
    output logic [N-1:0]        out_data,
    output logic [SEL_W-1:0]    out_src,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sel_err
);
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  g;
    logic [NUM_IN-1:0] grant;
    logic              load;
    logic              sel_ok;
    logic              xfer;

    // Walk the search order from the far end back toward p so the last hit,
    // i.e. the first valid channel at or after p, is the one left set.
    function automatic logic [NUM_IN-1:0] rr_pick(input logic [SEL_W-1:0] p, input logic [NUM_IN-1:0] v);
        rr_pick = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            int j;
            j = int'(p) + k;
            if (j >= NUM_IN) j -= NUM_IN;
            if (v[j]) begin
                rr_pick    = '0;
                rr_pick[j] = 1'b1;
            end
        end
    endfunction

    assign load     = ~out_valid | out_ready;
    assign sel_ok   = int'(sel) < NUM_IN;
    assign grant    = !load ? '0 :
                      mode  ? rr_pick(rr_ptr, in_valid) :
                      sel_ok ? ((NUM_IN'(1) << sel) & in_valid) : '0;
    assign in_ready = grant;
    assign xfer     = |grant;

    always_comb begin
        g = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (grant[i]) g = SEL_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_data  <= in_data[int'(g)*N +: N];
                out_src   <= g;
                out_valid <= 1'b1;
                if (mode) rr_ptr <= (g == SEL_W'(NUM_IN - 1)) ? '0 : g + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            sel_err <= ~mode & ~sel_ok & (|in_valid);
        end
    end
endmodule

// File: tb/tb_aes_state_sel_reg.sv
// tb_aes_state_sel_reg: directed scoreboard bench for aes_state_sel_reg (N=128, NUM_IN=3)
module tb_aes_state_sel_reg;
    typedef struct {
        logic [1:0]   src;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode = 1'b0;
    logic [1:0]   sel = '0;
    logic [383:0] in_data = '0;
    logic [2:0]   in_valid = '0;
    logic [2:0]   in_ready;
    logic [127:0] out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         sel_err;

    exp_t         sb[$];
    exp_t         held;
    int           n_assert = 0;
    int           n_fail = 0;
    int           step_cnt = 0;

    aes_state_sel_reg dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check the combinational grant, push the
    // expected word on a transfer, then check the register after the edge.
    task automatic step(input string tag, input logic m, input logic [1:0] s, input logic [2:0] v,
                        input logic ordy, input logic [2:0] exp_rdy);
        exp_t e;
        @(negedge clk);
        step_cnt++;
        for (int i = 0; i < 3; i++)
            in_data[i*128 +: 128] = {4{32'((i + 1) * 32'h1000_0000 + step_cnt)}};
        mode = m; sel = s; in_valid = v; out_ready = ordy;
        #1;
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(exp_rdy));
        if (exp_rdy != 3'b000) begin
            e.src  = exp_rdy[0] ? 2'd0 : exp_rdy[1] ? 2'd1 : 2'd2;
            e.data = in_data[int'(e.src)*128 +: 128];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (exp_rdy != 3'b000) begin
            held = sb.pop_front();
            chk({tag, ".out_valid"}, 128'(out_valid), 128'(1'b1));
            chk({tag, ".out_src"}, 128'(out_src), 128'(held.src));
            chk({tag, ".out_data"}, out_data, held.data);
        end else if (!ordy) begin
            chk({tag, ".hold_valid"}, 128'(out_valid), 128'(1'b1));
            chk({tag, ".hold_src"}, 128'(out_src), 128'(held.src));
            chk({tag, ".hold_data"}, out_data, held.data);
        end else begin
            chk({tag, ".out_valid"}, 128'(out_valid), 128'(1'b0));
        end
    endtask

    initial begin
        #2;
        chk("reset.out_valid", 128'(out_valid), 128'(1'b0));
        chk("reset.out_data", out_data, 128'h0);
        chk("reset.out_src", 128'(out_src), 128'h0);
        chk("reset.sel_err", 128'(sel_err), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step("expl_sel1", 1'b0, 2'd1, 3'b111, 1'b1, 3'b010);

        step("rr0", 1'b1, 2'd0, 3'b111, 1'b1, 3'b001);
        step("rr1", 1'b1, 2'd0, 3'b111, 1'b1, 3'b010);
        step("rr2", 1'b1, 2'd0, 3'b111, 1'b1, 3'b100);
        step("rr3", 1'b1, 2'd0, 3'b111, 1'b1, 3'b001);
        step("rr4", 1'b1, 2'd0, 3'b111, 1'b1, 3'b010);
        step("rr101_a", 1'b1, 2'd0, 3'b101, 1'b1, 3'b100);
        step("rr101_b", 1'b1, 2'd0, 3'b101, 1'b1, 3'b001);
        step("rr101_c", 1'b1, 2'd0, 3'b101, 1'b1, 3'b100);
        step("rr101_d", 1'b1, 2'd0, 3'b101, 1'b1, 3'b001);

        step("selerr", 1'b0, 2'd3, 3'b001, 1'b1, 3'b000);
        chk("selerr.pulse", 128'(sel_err), 128'(1'b1));

        step("bp_load", 1'b0, 2'd0, 3'b111, 1'b0, 3'b001);
        chk("selerr.cleared", 128'(sel_err), 128'(1'b0));
        for (int i = 0; i < 3; i++)
            step("bp_hold", 1'b0, 2'd0, 3'b111, 1'b0, 3'b000);
        step("bp_rel_a", 1'b0, 2'd1, 3'b111, 1'b1, 3'b010);
        step("bp_rel_b", 1'b0, 2'd2, 3'b111, 1'b1, 3'b100);

        #2;
        in_valid = 3'b000;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 128'(out_valid), 128'(1'b0));
        chk("arst.out_data", out_data, 128'h0);
        chk("arst.sel_err", 128'(sel_err), 128'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        step("sw_rr_first", 1'b1, 2'd0, 3'b111, 1'b1, 3'b001);
        step("sw_expl2", 1'b0, 2'd2, 3'b111, 1'b1, 3'b100);
        step("sw_rr_back", 1'b1, 2'd0, 3'b111, 1'b1, 3'b010);

        chk("scoreboard.empty", 128'(sb.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
